// File: rtl/sync_fifo_pkg.sv
// Shared FIFO definitions: pointer sizing and read-mode encodings.
// Intended for reuse by this FIFO and later FIFO variants.
package sync_fifo_pkg;

    // Read-mode encodings for the FWFT parameter.
    localparam int FWFT_OFF = 0;   // registered read, 1-cycle latency
    localparam int FWFT_ON  = 1;   // head word presented whenever non-empty

    // Pointer width: one extra bit beyond the RAM address.
    // The extra bit separates "same slot, empty" from "same slot, full".
    // Level and occupancy use the same width so they can hold DEPTH itself.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Handshake and status bundle between a FIFO and its user.
// The slave modport is the FIFO side; the master modport is the user side.
interface sync_fifo_if
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int DWIDTH = 8
);
    localparam int LVL_W = ptr_w(DEPTH);

    logic              clr_i;
    logic              wenc_i;
    logic [DWIDTH-1:0] wdata_i;
    logic              renc_i;
    logic [DWIDTH-1:0] rdata_o;
    logic              full_o;
    logic              empty_o;
    logic              afull_o;
    logic              aempty_o;
    logic [LVL_W-1:0]  level_o;
    logic              ovf_o;
    logic              udf_o;

    modport slave (
        input  clr_i, wenc_i, wdata_i, renc_i,
        output rdata_o, full_o, empty_o, afull_o, aempty_o, level_o, ovf_o, udf_o
    );

    modport master (
        output clr_i, wenc_i, wdata_i, renc_i,
        input  rdata_o, full_o, empty_o, afull_o, aempty_o, level_o, ovf_o, udf_o
    );

endinterface

// File: rtl/sync_fifo_mem.sv
// FIFO storage array: one write port, one read port, single clock, no reset.
// FWFT_OFF gives a registered read that updates only on re.
// FWFT_ON gives an asynchronous read of raddr.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int DWIDTH = 8,
    parameter int FWFT   = FWFT_OFF,
    localparam int AW    = ptr_w(DEPTH) - 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem_q [DEPTH];

    // Store the write word; the controller only raises we on an accepted write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    generate
        if (FWFT == FWFT_OFF) begin : g_reg_rd
            logic [DWIDTH-1:0] rdata_q;

            // Capture the head word on an accepted read; otherwise hold.
            always_ff @(posedge clk) begin
                if (re) begin
                    rdata_q <= mem_q[raddr];
                end
            end

            assign rdata = rdata_q;
        end else begin : g_async_rd
            // The read strobe has no effect when the read is asynchronous.
            logic unused_re;
            assign unused_re = re;
            assign rdata     = mem_q[raddr];
        end
    endgenerate

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO controller: pointers, occupancy, flags, sticky errors.
// All flags decode from registered level only. While rst_n is low, full and
// empty are forced high so that neither side can be accepted.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH     = 32,
    parameter int DWIDTH    = 8,
    parameter int FWFT      = FWFT_OFF,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    sync_fifo_if.slave  bus
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int AW    = PTR_W - 1;
    localparam int LVL_W = PTR_W;

    localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_AFULL  = LVL_W'(AFULL_TH);
    localparam logic [LVL_W-1:0] LVL_AEMPTY = LVL_W'(AEMPTY_TH);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic             full_w;
    logic             empty_w;
    logic             wr_acc;
    logic             rd_acc;
    logic [DWIDTH-1:0] mem_rdata;

    assign full_w  = !rst_n || (level_q == LVL_FULL);
    assign empty_w = !rst_n || (level_q == '0);

    // A flush overrides any simultaneous access. The flags are registered, so
    // on a full FIFO only the read is accepted, and on an empty FIFO only the
    // write is accepted.
    assign wr_acc = bus.wenc_i && !full_w  && !bus.clr_i;
    assign rd_acc = bus.renc_i && !empty_w && !bus.clr_i;

    // Next-state for pointers, level and sticky errors.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovf_d   = ovf_q || (bus.wenc_i && full_w);
        udf_d   = udf_q || (bus.renc_i && empty_w);

        if (bus.clr_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (wr_acc) begin
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (rd_acc) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            unique case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Control state registers; the asynchronous reset discards all content.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Pointer MSBs only track wrap parity; the separate level register
    // already resolves full against empty, so addressing uses the low bits.
    logic unused_ptr_msb;
    assign unused_ptr_msb = wptr_q[PTR_W-1] ^ rptr_q[PTR_W-1];

    sync_fifo_mem #(
        .DEPTH  (DEPTH),
        .DWIDTH (DWIDTH),
        .FWFT   (FWFT)
    ) u_mem (
        .clk    (clk),
        .we     (wr_acc),
        .waddr  (wptr_q[AW-1:0]),
        .wdata  (bus.wdata_i),
        .re     (rd_acc),
        .raddr  (rptr_q[AW-1:0]),
        .rdata  (mem_rdata)
    );

    generate
        if (FWFT == FWFT_OFF) begin : g_std_rd
            // The storage read register has no reset, so its output stays
            // masked to zero after reset until the first read reloads it.
            // A flush leaves this mask alone so that rdata_o holds.
            logic rd_valid_q;

            // Track whether the read register has been loaded since reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_valid_q <= 1'b0;
                end else if (rd_acc) begin
                    rd_valid_q <= 1'b1;
                end
            end

            assign bus.rdata_o = rd_valid_q ? mem_rdata : '0;
        end else begin : g_fwft_rd
            // The head word is visible in the cycle after it is written.
            // The output is zero while the FIFO is empty, including during reset.
            assign bus.rdata_o = empty_w ? '0 : mem_rdata;
        end
    endgenerate

    assign bus.full_o   = full_w;
    assign bus.empty_o  = empty_w;
    assign bus.afull_o  = (level_q >= LVL_AFULL);
    assign bus.aempty_o = (level_q <= LVL_AEMPTY);
    assign bus.level_o  = level_q;
    assign bus.ovf_o    = ovf_q;
    assign bus.udf_o    = udf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo using three configurations:
// a4 (DEPTH 4, standard read), b8 (DEPTH 8, thresholds 6/2), and
// c8 (DEPTH 8, first-word-fall-through).
module tb_sync_fifo;
    import sync_fifo_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sync_fifo_if #(.DEPTH(4), .DWIDTH(8)) a4 ();
    sync_fifo_if #(.DEPTH(8), .DWIDTH(8)) b8 ();
    sync_fifo_if #(.DEPTH(8), .DWIDTH(8)) c8 ();

    sync_fifo #(.DEPTH(4), .DWIDTH(8), .FWFT(FWFT_OFF)) u_a4 (
        .clk(clk), .rst_n(rst_n), .bus(a4)
    );
    sync_fifo #(.DEPTH(8), .DWIDTH(8), .FWFT(FWFT_OFF), .AFULL_TH(6), .AEMPTY_TH(2)) u_b8 (
        .clk(clk), .rst_n(rst_n), .bus(b8)
    );
    sync_fifo #(.DEPTH(8), .DWIDTH(8), .FWFT(FWFT_ON)) u_c8 (
        .clk(clk), .rst_n(rst_n), .bus(c8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        a4.clr_i = 1'b0; a4.wenc_i = 1'b0; a4.renc_i = 1'b0; a4.wdata_i = '0;
        b8.clr_i = 1'b0; b8.wenc_i = 1'b0; b8.renc_i = 1'b0; b8.wdata_i = '0;
        c8.clr_i = 1'b0; c8.wenc_i = 1'b0; c8.renc_i = 1'b0; c8.wdata_i = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        idle_all();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_full",   a4.full_o,   1);
        chk("rst_empty",  a4.empty_o,  1);
        chk("rst_level",  a4.level_o,  0);
        chk("rst_rdata",  a4.rdata_o,  0);
        chk("rst_aempty", a4.aempty_o, 1);
        chk("rst_afull",  a4.afull_o,  0);
        chk("rst_ovf",    a4.ovf_o,    0);
        chk("rst_udf",    a4.udf_o,    0);

        rst_n = 1'b1;
        #1;
        chk("rel_full",  a4.full_o,  0);
        chk("rel_empty", a4.empty_o, 1);

        // a4: fill 11..44, then overflow
        for (int i = 0; i < 4; i++) begin
            a4.wenc_i  = 1'b1;
            a4.wdata_i = 8'((i + 1) * 17);
            tick();
            chk("a4_fill_level", a4.level_o, 32'(i + 1));
        end
        chk("a4_full",  a4.full_o,  1);
        chk("a4_afull", a4.afull_o, 1);
        a4.wdata_i = 8'h55;
        tick();
        chk("a4_ovf",       a4.ovf_o,   1);
        chk("a4_ovf_level", a4.level_o, 4);
        chk("a4_ovf_full",  a4.full_o,  1);

        // a4: full with simultaneous write and read: only the read is accepted
        a4.wdata_i = 8'h66;
        a4.renc_i  = 1'b1;
        tick();
        chk("a4_wr_rd_full_rdata", a4.rdata_o, 8'h11);
        chk("a4_wr_rd_full_level", a4.level_o, 3);
        chk("a4_wr_rd_full_full",  a4.full_o,  0);
        a4.wenc_i = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("a4_drain_rdata", a4.rdata_o, 32'(8'((i + 1) * 17)));
            chk("a4_drain_level", a4.level_o, 32'(3 - i));
        end
        chk("a4_empty",  a4.empty_o,  1);
        chk("a4_aempty", a4.aempty_o, 1);
        tick();
        chk("a4_udf",        a4.udf_o,   1);
        chk("a4_udf_rdhold", a4.rdata_o, 8'h44);
        chk("a4_udf_level",  a4.level_o, 0);

        // a4: empty with simultaneous write and read: only the write is accepted
        a4.wenc_i  = 1'b1;
        a4.wdata_i = 8'h77;
        tick();
        chk("a4_wr_rd_empty_level", a4.level_o, 1);
        chk("a4_wr_rd_empty_rdata", a4.rdata_o, 8'h44);
        chk("a4_wr_rd_empty_empty", a4.empty_o, 0);
        a4.wenc_i = 1'b0;
        tick();
        chk("a4_rd77",       a4.rdata_o, 8'h77);
        chk("a4_rd77_level", a4.level_o, 0);
        a4.renc_i = 1'b0;

        // b8: thresholds while filling (afull at >=6, aempty at <=2)
        for (int i = 1; i <= 6; i++) begin
            b8.wenc_i  = 1'b1;
            b8.wdata_i = 8'(i);
            tick();
            chk("b8_fill_level",  b8.level_o,  32'(i));
            chk("b8_fill_afull",  b8.afull_o,  32'(i >= 6));
            chk("b8_fill_aempty", b8.aempty_o, 32'(i <= 2));
        end
        b8.wenc_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            b8.renc_i = 1'b1;
            tick();
            chk("b8_drain_rdata",  b8.rdata_o,  32'(i));
            chk("b8_drain_level",  b8.level_o,  32'(6 - i));
            chk("b8_drain_aempty", b8.aempty_o, 32'((6 - i) <= 2));
            chk("b8_drain_afull",  b8.afull_o,  0);
        end
        tick();
        chk("b8_rd5", b8.rdata_o, 5);
        tick();
        chk("b8_rd6",   b8.rdata_o, 6);
        chk("b8_empty", b8.empty_o, 1);
        chk("b8_udf_pre", b8.udf_o, 0);
        tick();
        chk("b8_udf",       b8.udf_o,   1);
        chk("b8_udf_level", b8.level_o, 0);
        b8.renc_i = 1'b0;

        // b8: steady stream at level 3 across pointer wrap
        for (int i = 0; i < 3; i++) begin
            b8.wenc_i  = 1'b1;
            b8.wdata_i = 8'(8'hA0 + i);
            tick();
        end
        chk("b8_lvl3", b8.level_o, 3);
        for (int k = 0; k < 20; k++) begin
            b8.wenc_i  = 1'b1;
            b8.wdata_i = 8'(8'hA3 + k);
            b8.renc_i  = 1'b1;
            tick();
            chk("b8_stream_level", b8.level_o, 3);
            chk("b8_stream_rdata", b8.rdata_o, 32'(8'(8'hA0 + k)));
        end
        b8.renc_i  = 1'b0;
        b8.wdata_i = 8'hC0;
        tick();
        b8.wdata_i = 8'hC1;
        tick();
        b8.wenc_i = 1'b0;
        chk("b8_lvl5", b8.level_o, 5);
        chk("b8_udf_sticky", b8.udf_o, 1);

        // b8: flush with a simultaneous write
        b8.clr_i   = 1'b1;
        b8.wenc_i  = 1'b1;
        b8.wdata_i = 8'hEE;
        tick();
        b8.clr_i  = 1'b0;
        b8.wenc_i = 1'b0;
        chk("b8_clr_level", b8.level_o, 0);
        chk("b8_clr_empty", b8.empty_o, 1);
        chk("b8_clr_ovf",   b8.ovf_o,   0);
        chk("b8_clr_udf",   b8.udf_o,   0);
        chk("b8_clr_rdata", b8.rdata_o, 8'hB3);
        b8.wenc_i  = 1'b1;
        b8.wdata_i = 8'h3C;
        tick();
        b8.wenc_i = 1'b0;
        b8.renc_i = 1'b1;
        tick();
        b8.renc_i = 1'b0;
        chk("b8_post_clr_rdata", b8.rdata_o, 8'h3C);
        chk("b8_post_clr_level", b8.level_o, 0);

        // a4: flush clears both sticky errors
        a4.clr_i = 1'b1;
        tick();
        a4.clr_i = 1'b0;
        chk("a4_clr_ovf", a4.ovf_o, 0);
        chk("a4_clr_udf", a4.udf_o, 0);

        // c8: first-word-fall-through
        c8.wenc_i  = 1'b1;
        c8.wdata_i = 8'hA5;
        tick();
        c8.wenc_i = 1'b0;
        chk("c8_empty0", c8.empty_o, 0);
        chk("c8_rdata",  c8.rdata_o, 8'hA5);
        chk("c8_level1", c8.level_o, 1);
        tick();
        chk("c8_rdata_hold", c8.rdata_o, 8'hA5);
        c8.wenc_i  = 1'b1;
        c8.wdata_i = 8'h5A;
        tick();
        c8.wenc_i = 1'b0;
        chk("c8_head_kept", c8.rdata_o, 8'hA5);
        chk("c8_level2",    c8.level_o, 2);
        c8.renc_i = 1'b1;
        tick();
        chk("c8_adv_rdata", c8.rdata_o, 8'h5A);
        chk("c8_adv_empty", c8.empty_o, 0);
        tick();
        c8.renc_i = 1'b0;
        chk("c8_empty1", c8.empty_o, 1);
        chk("c8_level0", c8.level_o, 0);

        // a4: reset in the middle of a burst
        a4.wenc_i  = 1'b1;
        a4.wdata_i = 8'h01;
        tick();
        tick();
        chk("a4_burst_level", a4.level_o, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("a4_midrst_full",  a4.full_o,  1);
        chk("a4_midrst_empty", a4.empty_o, 1);
        chk("a4_midrst_level", a4.level_o, 0);
        chk("a4_midrst_rdata", a4.rdata_o, 0);
        tick();
        rst_n = 1'b1;
        a4.wdata_i = 8'h09;
        #1;
        chk("a4_rel_level", a4.level_o, 0);
        chk("a4_rel_full",  a4.full_o,  0);
        chk("a4_rel_empty", a4.empty_o, 1);
        tick();
        chk("a4_first_wr", a4.level_o, 1);
        a4.wenc_i = 1'b0;
        a4.renc_i = 1'b1;
        tick();
        a4.renc_i = 1'b0;
        chk("a4_first_rd", a4.rdata_o, 8'h09);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
